seq_det_prog: RTL

//  Runtime-programmable serial pattern detector; successor to the fixed 4-bit Moore detectors.

---
 rtl/seq_det_prog.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: compares the last len consumed bits with a loaded pattern.
// Optional saturating match counter when SEQ_DET_CNT_EN is defined. Match latency 1 clk, no backpressure.
module seq_det_prog #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
`ifdef SEQ_DET_CNT_EN
  ,
  parameter int CNT_W   = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match,
  output logic               cfg_err,
  output logic               busy
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt,
  input  logic               cnt_clr
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_p1;
  logic               full;
  logic               hit;
  logic               cfg_ok;
  logic               load_ok;
  logic               consume;

  always_comb begin
    cand    = {hist, in};
    mask    = ~({MAX_LEN{1'b1}} << len);
    fill_p1 = {1'b0, fill} + (LEN_W+1)'(1);
    full    = fill_p1 >= {1'b0, len};
    hit     = (((cand ^ pattern) & mask) == '0) && full;
    cfg_ok  = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    load_ok = cfg_load && cfg_ok;
    // A legal load discards the bit presented in the same cycle.
    consume = enable && !load_ok && in_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      hist    <= '0;
      fill    <= '0;
      pattern <= '0;
      len     <= MAX_LEN_L;
      overlap <= 1'b1;
      match   <= 1'b0;
      cfg_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      match   <= consume && hit;
      if (load_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
      end
      if (!enable) begin
        state <= IDLE;
        hist  <= '0;
        fill  <= '0;
        busy  <= 1'b0;
      end else if (load_ok) begin
        state <= FILL;
        hist  <= '0;
        fill  <= '0;
        busy  <= 1'b1;
      end else begin
        busy <= 1'b1;
        if (in_valid) begin
          hist <= cand[MAX_LEN-2:0];
          if (hit && !overlap) begin
            // Non-overlapping: the next match must be built from fresh bits.
            fill  <= '0;
            state <= FILL;
          end else begin
            if (fill < len)
              fill <= fill_p1[LEN_W-1:0];
            state <= full ? RUN : FILL;
          end
        end else if (state == IDLE) begin
          state <= FILL;
        end
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      match_cnt <= '0;
    else if (cnt_clr)
      match_cnt <= '0;
    else if (consume && hit && (match_cnt != '1))
      match_cnt <= match_cnt + CNT_W'(1);
  end
`endif

endmodule
